adder_stim_gen: RTL

- Synthesizable initiator and checker for the lab adder's request/response interface.
- Generates pseudo-random operand pairs and issues them over a valid/ready handshake.
- Queues the expected sums, compares each returned sum in order, and keeps pass/fail counts.
- Sits on the other end of the adder interface, replacing a software test as the stimulus source for on-chip or emulation runs.

---
 rtl/adder_lab_pkg.sv | 23 ++
 rtl/adder_exp_fifo.sv | 49 ++++
 rtl/adder_stim_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/adder_lab_pkg.sv
// Shared types and constants for the adder lab stimulus generator.
package adder_lab_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;
    localparam int unsigned CORNER_CNT   = 4;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/adder_exp_fifo.sv
// Expected-sum FIFO: synchronous, power-of-two depth, combinational read of the head.
module adder_exp_fifo
    import adder_lab_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push && !full) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/adder_stim_gen.sv
// Stimulus generator and in-order checker for the lab adder request/response interface.
// Optional macro ADDER_STIM_CORNER_EN prefixes each run with four fixed corner operand pairs.
module adder_stim_gen
    import adder_lab_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_txn,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             req_valid,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [WIDTH:0]   rsp_sum,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
    output logic             err
);

    state_t           state_q,  state_d;
    logic [31:0]      lfsr_q,   lfsr_d;
    logic [15:0]      num_q,    num_d;
    logic [15:0]      issued_q, issued_d;
    logic [15:0]      recv_q,   recv_d;
    logic [15:0]      pass_q,   pass_d;
    logic [15:0]      fail_q,   fail_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             xfer_s, pop_s, start_ok_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [WIDTH:0]   exp_s, fifo_dout_s;

    // Valid depends only on registered state, so it cannot drop before req_ready is seen.
    assign req_valid = (state_q == RUN) && (issued_q < num_q) && !fifo_full_s;
    assign xfer_s    = req_valid && req_ready;
    assign pop_s     = rsp_valid && !fifo_empty_s;
    assign start_ok_s = start && (state_q != RUN);
    assign exp_s     = {1'b0, a_q} + {1'b0, b_q};

    adder_exp_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer_s),
        .pop   (pop_s),
        .din   (exp_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic for the run FSM, LFSR, operands and result counters.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        num_d    = num_q;
        issued_d = issued_q;
        recv_d   = recv_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;

        if (start_ok_s) begin
            num_d    = num_txn;
            issued_d = 16'd0;
            recv_d   = 16'd0;
            pass_d   = 16'd0;
            fail_d   = 16'd0;
            err_d    = 1'b0;
            state_d  = (num_txn == 16'd0) ? DONE : RUN;
        end else if (state_q == RUN && issued_q == num_q && recv_q == num_q) begin
            state_d = DONE;
        end else begin
            state_d = state_q;
        end

        if (xfer_s) begin
            issued_d = sat_inc16(issued_q);
`ifdef ADDER_STIM_CORNER_EN
            if (issued_q >= 16'(CORNER_CNT)) begin
                lfsr_d = lfsr_next(lfsr_q);
            end else begin
                lfsr_d = lfsr_q;
            end
`else
            lfsr_d = lfsr_next(lfsr_q);
`endif
        end else begin
            lfsr_d = lfsr_q;
        end

        if (rsp_valid) begin
            if (pop_s && (fifo_dout_s == rsp_sum)) begin
                pass_d = sat_inc16(pass_d);
            end else begin
                fail_d = sat_inc16(fail_d);
                err_d  = 1'b1;
            end
            if (pop_s) begin
                recv_d = sat_inc16(recv_d);
            end else begin
                recv_d = recv_d;
            end
        end else begin
            recv_d = recv_d;
        end

        if (start_ok_s || xfer_s) begin
`ifdef ADDER_STIM_CORNER_EN
            if (issued_d < 16'(CORNER_CNT)) begin
                case (issued_d[1:0])
                    2'd0:    begin a_d = {WIDTH{1'b0}}; b_d = {WIDTH{1'b0}}; end
                    2'd1:    begin a_d = {WIDTH{1'b1}}; b_d = {WIDTH{1'b0}}; end
                    2'd2:    begin a_d = {WIDTH{1'b1}}; b_d = {WIDTH{1'b1}}; end
                    default: begin a_d = {WIDTH{1'b0}}; b_d = {WIDTH{1'b1}}; end
                endcase
            end else begin
                a_d = lfsr_d[WIDTH-1:0];
                b_d = lfsr_d[WIDTH+15:16];
            end
`else
            a_d = lfsr_d[WIDTH-1:0];
            b_d = lfsr_d[WIDTH+15:16];
`endif
        end else begin
            a_d = a_q;
            b_d = b_q;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State registers; all outputs are driven straight from these.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            num_q    <= 16'd0;
            issued_q <= 16'd0;
            recv_q   <= 16'd0;
            pass_q   <= 16'd0;
            fail_q   <= 16'd0;
            err_q    <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;

endmodule
